// File: rtl/alu_ctrl_seq.sv
// ============================================================================
// Module   : alu_ctrl_seq
// Brief    : ALU control decoder with sequential unsigned multiply/divide and HI/LO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_ctrl_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             in_ready,
    output logic             out_valid,
    output logic [3:0]       alu_sel,
    output logic [1:0]       rd_src,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             illegal,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] c_SEL_AND  = 4'b0000;
    localparam logic [3:0] c_SEL_OR   = 4'b0001;
    localparam logic [3:0] c_SEL_ADD  = 4'b0010;
    localparam logic [3:0] c_SEL_SUB  = 4'b0110;
    localparam logic [3:0] c_SEL_SLT  = 4'b0111;
    localparam logic [3:0] c_SEL_NOR  = 4'b1100;
    localparam logic [3:0] c_SEL_NONE = 4'b1111;

    localparam logic [1:0] c_SRC_ALU  = 2'b00;
    localparam logic [1:0] c_SRC_HI   = 2'b01;
    localparam logic [1:0] c_SRC_LO   = 2'b10;
    localparam logic [1:0] c_SRC_NONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       sel_q, sel_d;
    logic [1:0]       src_q, src_d;
    logic             ill_q, ill_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;

    logic [3:0]       w_dec_sel;
    logic [1:0]       w_dec_src;
    logic             w_dec_ill;
    logic             w_is_mul;
    logic             w_is_div;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;

    always_comb begin
        w_dec_sel = c_SEL_NONE;
        w_dec_src = c_SRC_NONE;
        w_dec_ill = 1'b0;
        w_is_mul  = 1'b0;
        w_is_div  = 1'b0;
        case (alu_op)
            2'b00: begin
                w_dec_sel = c_SEL_ADD;
                w_dec_src = c_SRC_ALU;
            end
            2'b01: begin
                w_dec_sel = c_SEL_SUB;
                w_dec_src = c_SRC_NONE;
            end
            2'b10: begin
                case (funct)
                    6'b100000: begin w_dec_sel = c_SEL_ADD; w_dec_src = c_SRC_ALU; end
                    6'b100010: begin w_dec_sel = c_SEL_SUB; w_dec_src = c_SRC_ALU; end
                    6'b100100: begin w_dec_sel = c_SEL_AND; w_dec_src = c_SRC_ALU; end
                    6'b100101: begin w_dec_sel = c_SEL_OR;  w_dec_src = c_SRC_ALU; end
                    6'b101010: begin w_dec_sel = c_SEL_SLT; w_dec_src = c_SRC_ALU; end
                    6'b100111: begin w_dec_sel = c_SEL_NOR; w_dec_src = c_SRC_ALU; end
                    6'b010000: w_dec_src = c_SRC_HI;
                    6'b010010: w_dec_src = c_SRC_LO;
                    6'b011000: w_is_mul  = 1'b1;
                    6'b011010: w_is_div  = 1'b1;
                    default:   w_dec_ill = 1'b1;
                endcase
            end
            default: w_dec_ill = 1'b1;
        endcase
    end

    // Multiply: acc_lo holds the shrinking multiplier, product bits shift in from the top.
    always_comb begin
        w_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        w_mul_hi = w_sum[WIDTH:1];
        w_mul_lo = {w_sum[0], acc_lo_q[WIDTH-1:1]};
    end

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    always_comb begin
        w_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        w_trial = w_shift - {1'b0, opnd_q};
        if (!w_trial[WIDTH]) begin
            w_div_rem = w_trial[WIDTH-1:0];
            w_div_quo = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
            w_div_rem = w_shift[WIDTH-1:0];
            w_div_quo = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        src_d    = src_q;
        ill_d    = ill_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sel_d    = w_dec_sel;
                    src_d    = w_dec_src;
                    ill_d    = w_dec_ill;
                    dz_d     = 1'b0;
                    cnt_d    = '0;
                    acc_hi_d = '0;
                    acc_lo_d = a;
                    opnd_d   = b;
                    state_d  = DONE;
                    if (w_is_mul) begin
                        state_d = MUL;
                    end else if (w_is_div) begin
                        if (b == '0) begin
                            dz_d = 1'b1;
                            hi_d = a;
                            lo_d = '1;
                        end else begin
                            state_d = DIV;
                        end
                    end
                end
            end
            MUL: begin
                acc_hi_d = w_mul_hi;
                acc_lo_d = w_mul_lo;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    hi_d    = w_mul_hi;
                    lo_d    = w_mul_lo;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DIV: begin
                acc_hi_d = w_div_rem;
                acc_lo_d = w_div_quo;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    hi_d    = w_div_rem;
                    lo_d    = w_div_quo;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= 4'b0000;
            src_q    <= c_SRC_NONE;
            ill_q    <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            src_q    <= src_d;
            ill_q    <= ill_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign alu_sel   = sel_q;
    assign rd_src    = src_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign illegal   = ill_q;
    assign div_zero  = dz_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
// ============================================================================
// Module   : tb_alu_ctrl_seq
// Brief    : Directed self-checking bench for alu_ctrl_seq at WIDTH=8.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_ctrl_seq;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic [1:0]   alu_op;
    logic [5:0]   funct;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         in_ready;
    logic         out_valid;
    logic [3:0]   alu_sel;
    logic [1:0]   rd_src;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         illegal;
    logic         div_zero;

    int total = 0;
    int bad   = 0;

    alu_ctrl_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .alu_op    (alu_op),
        .funct     (funct),
        .a         (a),
        .b         (b),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .alu_sel   (alu_sel),
        .rd_src    (rd_src),
        .hi        (hi),
        .lo        (lo),
        .illegal   (illegal),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Accept one request on the next edge; leaves the bench just after that edge.
    task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                         input logic [W-1:0] av, input logic [W-1:0] bv);
        in_valid = 1'b1;
        alu_op   = op;
        funct    = fn;
        a        = av;
        b        = bv;
        step();
        in_valid = 1'b0;
    endtask

    task automatic single(input string tag, input logic [1:0] op, input logic [5:0] fn,
                          input logic [3:0] esel, input logic [1:0] esrc, input logic eill,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo);
        issue(op, fn, 8'hA5, 8'h3C);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".ready"}, 64'(in_ready), 64'd0);
        chk({tag, ".sel"}, 64'(alu_sel), 64'(esel));
        chk({tag, ".src"}, 64'(rd_src), 64'(esrc));
        chk({tag, ".ill"}, 64'(illegal), 64'(eill));
        chk({tag, ".dz"}, 64'(div_zero), 64'd0);
        chk({tag, ".hi"}, 64'(hi), 64'(ehi));
        chk({tag, ".lo"}, 64'(lo), 64'(elo));
        step();
        chk({tag, ".ready2"}, 64'(in_ready), 64'd1);
        chk({tag, ".valid2"}, 64'(out_valid), 64'd0);
    endtask

    // Multi-cycle op; bus is scrambled and in_valid held high while busy.
    task automatic longop(input string tag, input logic [5:0] fn,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo);
        logic [W-1:0] hi0;
        logic [W-1:0] lo0;
        int n;
        hi0 = hi;
        lo0 = lo;
        issue(2'b10, fn, av, bv);
        in_valid = 1'b1;
        alu_op   = 2'b10;
        funct    = 6'b100000;
        a        = ~av;
        b        = ~bv;
        n = 1;
        while (!out_valid && n < 20) begin
            chk({tag, ".busy_ready"}, 64'(in_ready), 64'd0);
            chk({tag, ".busy_hi"}, 64'(hi), 64'(hi0));
            chk({tag, ".busy_lo"}, 64'(lo), 64'(lo0));
            step();
            n++;
        end
        in_valid = 1'b0;
        chk({tag, ".latency"}, 64'(n), 64'd9);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".hi"}, 64'(hi), 64'(ehi));
        chk({tag, ".lo"}, 64'(lo), 64'(elo));
        chk({tag, ".sel"}, 64'(alu_sel), 64'hF);
        chk({tag, ".src"}, 64'(rd_src), 64'h3);
        chk({tag, ".dz"}, 64'(div_zero), 64'd0);
        chk({tag, ".ill"}, 64'(illegal), 64'd0);
        step();
        chk({tag, ".ready_after"}, 64'(in_ready), 64'd1);
    endtask

    logic [5:0] rfn  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
    logic [3:0] rsel [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        alu_op   = 2'b00;
        funct    = 6'b000000;
        a        = '0;
        b        = '0;
        step();
        step();
        chk("rst.ready", 64'(in_ready), 64'd1);
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.sel", 64'(alu_sel), 64'h0);
        chk("rst.src", 64'(rd_src), 64'h3);
        chk("rst.hi", 64'(hi), 64'h0);
        chk("rst.lo", 64'(lo), 64'h0);
        chk("rst.ill", 64'(illegal), 64'd0);
        chk("rst.dz", 64'(div_zero), 64'd0);

        // Reset wins over a simultaneous request.
        in_valid = 1'b1;
        alu_op   = 2'b10;
        funct    = 6'b100000;
        step();
        chk("rstprio.ready", 64'(in_ready), 64'd1);
        chk("rstprio.valid", 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        reset    = 1'b0;
        step();

        single("slt", 2'b10, 6'b101010, 4'b0111, 2'b00, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 6; i++)
            single($sformatf("rtype%0d", i), 2'b10, rfn[i], rsel[i], 2'b00, 1'b0, 8'h00, 8'h00);
        single("ldst", 2'b00, 6'b111111, 4'b0010, 2'b00, 1'b0, 8'h00, 8'h00);
        single("branch", 2'b01, 6'b000000, 4'b0110, 2'b11, 1'b0, 8'h00, 8'h00);

        longop("mul200x3", 6'b011000, 8'd200, 8'd3, 8'h02, 8'h58);
        longop("div100by7", 6'b011010, 8'd100, 8'd7, 8'd2, 8'd14);
        single("mfhi", 2'b10, 6'b010000, 4'b1111, 2'b01, 1'b0, 8'd2, 8'd14);
        single("mflo", 2'b10, 6'b010010, 4'b1111, 2'b10, 1'b0, 8'd2, 8'd14);

        issue(2'b10, 6'b011010, 8'h5A, 8'h00);
        chk("div0.valid", 64'(out_valid), 64'd1);
        chk("div0.lo", 64'(lo), 64'hFF);
        chk("div0.hi", 64'(hi), 64'h5A);
        chk("div0.dz", 64'(div_zero), 64'd1);
        chk("div0.sel", 64'(alu_sel), 64'hF);
        chk("div0.src", 64'(rd_src), 64'h3);
        step();
        chk("div0.ready_after", 64'(in_ready), 64'd1);

        single("ill_op11", 2'b11, 6'b100000, 4'b1111, 2'b11, 1'b1, 8'h5A, 8'hFF);
        single("ill_fn01", 2'b10, 6'b000001, 4'b1111, 2'b11, 1'b1, 8'h5A, 8'hFF);
        single("add_clr", 2'b10, 6'b100000, 4'b0010, 2'b00, 1'b0, 8'h5A, 8'hFF);

        // Abort a multiply four cycles in.
        issue(2'b10, 6'b011000, 8'd255, 8'd255);
        for (int i = 0; i < 4; i++) begin
            chk("abort.busy_valid", 64'(out_valid), 64'd0);
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort.ready", 64'(in_ready), 64'd1);
        chk("abort.hi", 64'(hi), 64'h0);
        chk("abort.lo", 64'(lo), 64'h0);
        chk("abort.src", 64'(rd_src), 64'h3);
        chk("abort.sel", 64'(alu_sel), 64'h0);
        for (int i = 0; i < 12; i++) begin
            chk("abort.no_valid", 64'(out_valid), 64'd0);
            step();
        end

        longop("mul255x255", 6'b011000, 8'd255, 8'd255, 8'hFE, 8'h01);
        longop("div255by16", 6'b011010, 8'd255, 8'd16, 8'h0F, 8'h0F);
        longop("div5by9", 6'b011010, 8'd5, 8'd9, 8'h05, 8'h00);
        longop("mul0x77", 6'b011000, 8'd0, 8'h77, 8'h00, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
